hdmi_pixel_feeder: RTL

HDMI_PIXEL_FEEDER -- requirements
Module: hdmi_pixel_feeder

---
 rtl/hdmi_pixel_feeder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hdmi_pixel_feeder.sv
// hdmi_pixel_feeder
// Generates raster timing (x/y counters, hsync, vsync, draw area) and feeds
// pixels from a small FIFO to an HDMI encoder running on the same clock.
//
// Ports:
//   pi_clk            pixel clock (only clock)
//   pi_rst            asynchronous active-high reset
//   pi_pixel[23:0]    {red, green, blue} from the upstream source
//   pi_valid          pi_pixel valid this cycle
//   po_ready          FIFO can accept a pixel this cycle
//   pi_clr_underflow  single-cycle clear of po_underflow
//   po_red/green/blue pixel to the encoder (1-cycle latency from draw)
//   po_draw_area      registered draw flag, aligned with RGB
//   po_hsync/po_vsync registered syncs, aligned with RGB
//   po_x/po_y         live counter values
//   po_frame_start    high while x=0 and y=0
//   po_underflow      sticky: draw cycle found the FIFO empty
//
// Handshake: a pixel is accepted on a rising edge where pi_valid && po_ready.
// po_ready depends only on the registered FIFO count, never on pi_valid.
module hdmi_pixel_feeder #(
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int HS_START   = 656,
  parameter int HS_END     = 752,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int VS_START   = 490,
  parameter int VS_END     = 492,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        pi_clk,
  input  logic        pi_rst,
  input  logic [23:0] pi_pixel,
  input  logic        pi_valid,
  output logic        po_ready,
  input  logic        pi_clr_underflow,
  output logic [7:0]  po_red,
  output logic [7:0]  po_green,
  output logic [7:0]  po_blue,
  output logic        po_draw_area,
  output logic        po_hsync,
  output logic        po_vsync,
  output logic [9:0]  po_x,
  output logic [9:0]  po_y,
  output logic        po_frame_start,
  output logic        po_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [9:0]    L_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0]    L_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    L_HS_START = 10'(HS_START);
  localparam logic [9:0]    L_HS_END   = 10'(HS_END);
  localparam logic [9:0]    L_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0]    L_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    L_VS_START = 10'(VS_START);
  localparam logic [9:0]    L_VS_END   = 10'(VS_END);
  localparam logic [AW:0]   L_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   L_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR_ONE  = AW'(1);

  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [23:0]   r_rgb;
  logic          r_draw;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_underflow;

  logic w_draw;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_hs;
  logic w_vs;

  always_comb begin
    w_draw   = (r_x < L_H_ACTIVE) && (r_y < L_V_ACTIVE);
    w_empty  = (r_count == '0);
    po_ready = (r_count < L_DEPTH);
    w_push   = pi_valid && po_ready;
    // An empty FIFO during draw is an underflow, not a pop.
    w_pop    = w_draw && !w_empty;
    w_hs     = (r_x >= L_HS_START) && (r_x < L_HS_END);
    w_vs     = (r_y >= L_VS_START) && (r_y < L_VS_END);
  end

  // Raster counters: y advances on each x wrap.
  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_x == L_H_LAST) begin
      r_x <= '0;
      r_y <= (r_y == L_V_LAST) ? '0 : r_y + 10'd1;
    end else begin
      r_x <= r_x + 10'd1;
    end
  end

  // Storage carries no reset; clearing the pointers/count discards contents.
  always_ff @(posedge pi_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pi_pixel;
  end

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + L_CNT_ONE;
        2'b01:   r_count <= r_count - L_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: RGB and timing share one register stage.
  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      r_rgb   <= '0;
      r_draw  <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_rgb   <= w_pop ? r_mem[r_rd_ptr] : 24'h0;
      r_draw  <= w_draw;
      r_hsync <= w_hs;
      r_vsync <= w_vs;
    end
  end

  // A new underflow takes priority over a simultaneous clear.
  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst)                  r_underflow <= 1'b0;
    else if (w_draw && w_empty)  r_underflow <= 1'b1;
    else if (pi_clr_underflow)   r_underflow <= 1'b0;
  end

  assign po_red         = r_rgb[23:16];
  assign po_green       = r_rgb[15:8];
  assign po_blue        = r_rgb[7:0];
  assign po_draw_area   = r_draw;
  assign po_hsync       = r_hsync;
  assign po_vsync       = r_vsync;
  assign po_x           = r_x;
  assign po_y           = r_y;
  assign po_frame_start = (r_x == '0) && (r_y == '0);
  assign po_underflow   = r_underflow;

endmodule
